rgb_led_pwm: RTL and testbench

Parametrised multi-channel RGB LED driver for the board status LEDs, clocked from the system clock. Each LED has its own mode and 24-bit-class colour; the block generates glitch-free PWM per colour channel with static, blink, breathing and binary-counter display modes. It replaces the free-running bring-up counter on the LED pins and sits between the control logic (register writes) and the `led_rgbN` pads.

---
 rtl/rgb_led_pwm.sv | 164 ++++++++++++++++
 tb/tb_rgb_led_pwm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - multi-LED RGB PWM driver; optional gamma stage under `RGB_LED_GAMMA_EN
module rgb_led_pwm #(
  parameter int N_LEDS     = 4,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 4,
  parameter int BLINK_BITS = 6,
  parameter int ACTIVE_LOW = 1,
  localparam int AW        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                  fpga_sysclk,
  input  logic                  rst_fpga,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [2:0]            wr_mode,
  input  logic [3*PWM_BITS-1:0] wr_color,
  output logic                  frame_start,
  output logic [3*N_LEDS-1:0]   led_rgb
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] MODE_STATIC  = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_BREATHE = 3'd3;
  localparam logic [2:0] MODE_COUNT   = 3'd4;

  // Pin level that leaves an LED dark
  localparam logic PIN_OFF = (ACTIVE_LOW != 0);

  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  frame_end;
  logic [31:0]           frame_cnt;
  logic [PWM_BITS-1:0]   env;
  logic                  env_up;

  logic [2:0]            sh_mode   [N_LEDS];
  logic [3*PWM_BITS-1:0] sh_color  [N_LEDS];
  logic [2:0]            act_mode  [N_LEDS];
  logic [3*PWM_BITS-1:0] act_color [N_LEDS];

  logic [2:0]            cnt_sel   [N_LEDS];
  logic [PWM_BITS-1:0]   duty      [N_LEDS][3];
  logic [3*N_LEDS-1:0]   pin_d;

  assign tick        = (pre_cnt == PW'(PRESCALE - 1));
  assign frame_end   = tick && (pwm_cnt == '1);
  assign frame_start = !rst_fpga && (pre_cnt == '0) && (pwm_cnt == '0);

  // (a * b) >> PWM_BITS on a double-width product, truncated
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] a,
                                                input logic [PWM_BITS-1:0] b);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, a} * {{PWM_BITS{1'b0}}, b};
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  // Duty of one colour channel for the current frame
  function automatic logic [PWM_BITS-1:0] chan_duty(input logic [2:0]          mode,
                                                    input logic [PWM_BITS-1:0] color,
                                                    input logic [PWM_BITS-1:0] env_v,
                                                    input logic                blink_dark,
                                                    input logic                cnt_on);
    logic [PWM_BITS-1:0] d;
    d = '0;
    case (mode)
      MODE_STATIC:  d = color;
      MODE_BLINK:   d = blink_dark ? '0 : color;
      MODE_BREATHE: d = scale(color, env_v);
      MODE_COUNT:   d = cnt_on ? '1 : '0;
      default:      d = '0;
    endcase
`ifdef RGB_LED_GAMMA_EN
    d = scale(d, d);
`endif
    return d;
  endfunction

  // Prescaler and PWM counter; the frame is 2^PWM_BITS ticks
  always_ff @(posedge fpga_sysclk) begin
    if (rst_fpga) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Frame counter and triangle envelope; endpoints are held one extra frame
  always_ff @(posedge fpga_sysclk) begin
    if (rst_fpga) begin
      frame_cnt <= '0;
      env       <= '0;
      env_up    <= 1'b1;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 32'd1;
      if (env_up) begin
        if (env == '1) env_up <= 1'b0;
        else           env    <= env + 1'b1;
      end else begin
        if (env == '0) env_up <= 1'b1;
        else           env    <= env - 1'b1;
      end
    end
  end

  // Writes land in the shadow; the shadow becomes active at each frame start
  always_ff @(posedge fpga_sysclk) begin
    if (rst_fpga) begin
      for (int i = 0; i < N_LEDS; i++) begin
        sh_mode[i]   <= '0;
        sh_color[i]  <= '0;
        act_mode[i]  <= '0;
        act_color[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          sh_mode[i]  <= wr_mode;
          sh_color[i] <= wr_color;
        end
        if (frame_start) begin
          act_mode[i]  <= sh_mode[i];
          act_color[i] <= sh_color[i];
        end
      end
    end
  end

  // Effective duty; on the frame_start clock the shadow is about to become
  // active, so it is used directly to keep the first tick of the frame correct
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      cnt_sel[i] = 3'(frame_cnt >> (3 * i + BLINK_BITS));
      for (int c = 0; c < 3; c++) begin
        duty[i][c] = chan_duty(frame_start ? sh_mode[i] : act_mode[i],
                               frame_start ? sh_color[i][c*PWM_BITS +: PWM_BITS]
                                           : act_color[i][c*PWM_BITS +: PWM_BITS],
                               env, frame_cnt[BLINK_BITS-1], cnt_sel[i][c]);
      end
    end
  end

  // PWM compare and pin polarity
  always_comb begin
    pin_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      for (int c = 0; c < 3; c++) begin
        pin_d[3*i+c] = (pwm_cnt < duty[i][c]) ^ PIN_OFF;
      end
    end
  end

  // Registered pins, dark while in reset
  always_ff @(posedge fpga_sysclk) begin
    if (rst_fpga) led_rgb <= {(3*N_LEDS){PIN_OFF}};
    else          led_rgb <= pin_d;
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb/tb_rgb_led_pwm.sv - randomized self-checking bench for rgb_led_pwm
module tb_rgb_led_pwm;

  localparam int N_LEDS     = 5;
  localparam int PWM_BITS   = 5;
  localparam int PRESCALE   = 2;
  localparam int BLINK_BITS = 3;
  localparam int ACTIVE_LOW = 1;
  localparam int AW         = 3;
  localparam int CW         = 3 * PWM_BITS;
  localparam int DMAX       = (1 << PWM_BITS) - 1;
  localparam int FRAME      = (1 << PWM_BITS) * PRESCALE;
  localparam logic [3*N_LEDS-1:0] INACT = '1;

  logic                fpga_sysclk = 1'b0;
  logic                rst_fpga    = 1'b1;
  logic                wr_en       = 1'b0;
  logic [AW-1:0]       wr_addr     = '0;
  logic [2:0]          wr_mode     = '0;
  logic [CW-1:0]       wr_color    = '0;
  logic                frame_start;
  logic [3*N_LEDS-1:0] led_rgb;

  rgb_led_pwm #(
    .N_LEDS(N_LEDS), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
    .BLINK_BITS(BLINK_BITS), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .fpga_sysclk(fpga_sysclk), .rst_fpga(rst_fpga), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_mode(wr_mode), .wr_color(wr_color),
    .frame_start(frame_start), .led_rgb(led_rgb)
  );

  always #5 fpga_sysclk = ~fpga_sysclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: shadow registers, frame snapshot and per-frame duties
  int                  m_mode  [N_LEDS];
  int                  m_color [N_LEDS];
  int                  m_duty  [N_LEDS][3];
  longint              cyc     = 0;
  logic [3*N_LEDS-1:0] exp_led = INACT;
  bit                  prev_rst = 1'b0;

  // Triangle 0..DMAX..0 with each endpoint shown for two consecutive frames
  function automatic int env_of(input longint k);
    longint p;
    if (k == 0) return 0;
    p = (k - 1) % (2 * (DMAX + 1));
    if (p < DMAX)         return int'(p) + 1;
    if (p == DMAX)        return DMAX;
    if (p < 2 * DMAX + 1) return 2 * DMAX - int'(p);
    return 0;
  endfunction

  function automatic int duty_of(input int mode, input int color, input longint k,
                                 input int led, input int ch);
    int c, d;
    c = (color >> (ch * PWM_BITS)) & DMAX;
    case (mode)
      1:       d = c;
      2:       d = (((k >> (BLINK_BITS - 1)) & 1) != 0) ? 0 : c;
      3:       d = (c * env_of(k)) >> PWM_BITS;
      4:       d = (((k >> (3 * led + BLINK_BITS + ch)) & 1) != 0) ? DMAX : 0;
      default: d = 0;
    endcase
`ifdef RGB_LED_GAMMA_EN
    d = (d * d) >> PWM_BITS;
`endif
    return d;
  endfunction

  // Sample on the falling edge, then advance the model by one clock
  always @(negedge fpga_sysclk) begin
    int  t;
    bit  on;
    if (rst_fpga) begin
      check("frame_start_in_reset", frame_start, 1'b0);
      if (prev_rst) check("led_in_reset", led_rgb, INACT);
      cyc     = 0;
      exp_led = INACT;
      for (int i = 0; i < N_LEDS; i++) begin
        m_mode[i]  = 0;
        m_color[i] = 0;
      end
    end else begin
      check("frame_start", frame_start, (cyc % FRAME) == 0);
      check("led_rgb", led_rgb, exp_led);
      t = int'(cyc % FRAME);
      if (t == 0) begin
        for (int i = 0; i < N_LEDS; i++)
          for (int ch = 0; ch < 3; ch++)
            m_duty[i][ch] = duty_of(m_mode[i], m_color[i], cyc / FRAME, i, ch);
      end
      for (int i = 0; i < N_LEDS; i++) begin
        for (int ch = 0; ch < 3; ch++) begin
          on = (t / PRESCALE) < m_duty[i][ch];
          exp_led[3*i+ch] = (ACTIVE_LOW != 0) ? !on : on;
        end
      end
      if (wr_en && (int'(wr_addr) < N_LEDS)) begin
        m_mode[wr_addr]  = int'(wr_mode);
        m_color[wr_addr] = int'(wr_color);
      end
      cyc++;
    end
    prev_rst = rst_fpga;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge fpga_sysclk);
      #1;
    end
  endtask

  task automatic wr(input int addr, input int mode, input int color);
    wr_en    = 1'b1;
    wr_addr  = AW'(addr);
    wr_mode  = 3'(mode);
    wr_color = CW'(color);
    step(1);
    wr_en    = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (((cyc % FRAME) != ph) && (n < 2 * FRAME)) begin
      step(1);
      n++;
    end
    if (n >= 2 * FRAME) check("wait_phase_timeout", 1'b0, 1'b1);
  endtask

  function automatic int rgb(input int r, input int g, input int b);
    return (r << (2 * PWM_BITS)) | (g << PWM_BITS) | b;
  endfunction

  initial begin
    step(3);
    rst_fpga = 1'b0;

    wait_phase(5);
    wr(1, 1, rgb(8, 0, DMAX));
    step(2 * FRAME);

    wait_phase(FRAME - 10);
    wr(0, 1, rgb(20, 5, 12));
    wait_phase(0);
    wr(0, 1, rgb(3, 30, 17));
    step(2 * FRAME);

    wait_phase(FRAME - 2);
    wr(2, 1, rgb(1, 2, 3));
    wr(2, 2, rgb(DMAX, DMAX, DMAX));
    wr(3, 3, rgb(DMAX, 0, 0));
    wr(4, 4, 0);
    wr(5, 1, rgb(DMAX, DMAX, DMAX));
    wr(7, 2, rgb(9, 9, 9));
    step(70 * FRAME);

    wait_phase(20);
    rst_fpga = 1'b1;
    step(2);
    rst_fpga = 1'b0;
    wr(3, 3, rgb(DMAX, 16, 7));
    wr(4, 4, rgb(1, 1, 1));
    step(3 * FRAME);

    for (int n = 0; n < 700 * FRAME; n++) begin
      if ($urandom_range(0, 99) < 2)
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, (1 << CW) - 1)));
      else
        step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
